fib_req_driver: RTL and testbench
=================================

Name: fib_req_driver

Overview:
- Initiator for the fib core's start/ready/done_tick handshake.
- Accepts a range command (first index, count) and issues one fib request per index, strictly one outstanding at a time.
- Captures each fib_f result into a small result FIFO and streams index/value pairs out with valid/ready backpressure.
- Guards every request with a timeout, so a hung core cannot stall the system.

Parameters:
- IDX_W, 5, width of the Fibonacci index.
- F_W, 20, width of the Fibonacci result.
- MAX_IDX, 30, highest index issued; a command is truncated at this index.
- RES_DEPTH, 4, result FIFO depth; power of 2, minimum 2.
- TIMEOUT_CYC, 1023, maximum cycles from fib_start to fib_done_tick.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_first  in  IDX_W  first index of the range.
- cmd_count  in  IDX_W  number of indices minus 1 (range 1..32).
- fib_start  out  1  one-cycle request pulse to the core.
- fib_i  out  IDX_W  request index; valid while fib_start=1.
- fib_ready  in  1  core idle.
- fib_done_tick  in  1  core result pulse.
- fib_f  in  F_W  core result, valid with fib_done_tick.
- res_valid  out  1  FIFO not empty.
- res_ready  in  1  downstream accept.
- res_idx  out  IDX_W  index of the head entry.
- res_f  out  F_W  value of the head entry (0 when res_err=1).
- res_last  out  1  head entry is the last of its command.
- res_err  out  1  head entry is a timeout abort.
- busy  out  1  state != IDLE.
- timeout_sticky  out  1  set on any timeout; cleared only by reset.

Behaviour:
- Reset: state=IDLE, FIFO empty. All outputs 0 except cmd_ready=1.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch cur=cmd_first and last=min(cmd_first+cmd_count, MAX_IDX), computed 6-bit with no wrap; go to ISSUE.
  - If cmd_first>MAX_IDX: push one entry {idx=cmd_first, f=0, last=1, err=1}, stay in IDLE.
- ISSUE:
  - Wait until fib_ready=1 and the FIFO has a free slot, so a result can never be dropped.
  - Then drive fib_start=1 with fib_i=cur for exactly 1 cycle, clear the timer, go to WAIT.
- WAIT:
  - Timer counts every cycle.
  - On fib_done_tick: write {cur, fib_f, last=(cur==last), err=0} into the FIFO. Then go to IDLE if cur==last, else cur<=cur+1 and go to ISSUE.
  - fib_done_tick in IDLE or ISSUE is ignored.
  - Timer reaching TIMEOUT_CYC with no tick: write {cur, 0, last=1, err=1}, set timeout_sticky, drop the remaining indices, go to IDLE.
  - Tick and timeout in the same cycle: the tick wins.
- Result FIFO:
  - A written entry is visible on res_valid the next cycle.
  - Pop happens when res_valid && res_ready.
  - Simultaneous push and pop on a full FIFO is legal; the entry count is unchanged.
  - Head outputs hold stable while res_valid=1 and res_ready=0.
- Latency:
  - cmd accept to first fib_start: 1 cycle (core ready, FIFO space).
  - fib_done_tick to res_valid: 1 cycle (empty FIFO).
  - fib_done_tick to next fib_start: 1 cycle.
- Reset mid-operation: any in-flight core result is discarded; the FIFO is flushed; fib_start is never asserted in the reset cycle.

Decomposition:
- Package fib_pkg:
  - IDX_W and F_W defaults.
  - State enum {IDLE, ISSUE, WAIT}.
  - Result-entry struct {idx, f, last, err}.
- One sub-module, fib_res_fifo: synchronous FIFO of the entry struct with full/empty and a free-slot flag.

Test Plan:
- cmd_first=0, cmd_count=8, res_ready=1 -> results (0,0),(1,1),(2,1),(3,2),(4,3),(5,5),(6,8),(7,13),(8,21) in order; res_last only on idx 8; exactly 9 fib_start pulses, each 1 cycle.
- cmd_first=10, cmd_count=3, res_ready=0 throughout -> 4 results fill the FIFO; fib_start stays 0 after the 4th request. Then res_ready=1 -> (10,55),(11,89),(12,144),(13,233) with res_last on 13, and no further fib_start pulses (the command is complete).
- cmd_first=28, cmd_count=7 -> only idx 28,29,30 are issued; (30,832040) carries res_last=1.
- Core model never pulses fib_done_tick for i=3, cmd_first=2, cmd_count=4 -> (2,1) is output, then after 1023 cycles (3,0,last=1,err=1); timeout_sticky=1; cmd_ready=1 next cycle.
- reset asserted for 1 cycle while in WAIT -> FIFO empty, busy=0, cmd_ready=1. A late fib_done_tick produces no result. A new command cmd_first=5, cmd_count=0 then yields (5,5).
- cmd_first=31 -> a single err entry; no fib_start is issued.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared types for the fib request driver: state encoding and the result-entry record.
package fib_pkg;

  localparam int DEF_IDX_W = 5;
  localparam int DEF_F_W   = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef struct packed {
    logic [DEF_IDX_W-1:0] idx;
    logic [DEF_F_W-1:0]   f;
    logic                 last;
    logic                 err;
  } res_entry_t;

endpackage

// File: rtl/fib_res_fifo.sv
// Synchronous result FIFO; a push while full is only taken when a pop frees the slot in the same cycle.
module fib_res_fifo
  import fib_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  res_entry_t push_entry,
  input  logic       pop,
  output res_entry_t head,
  output logic       empty,
  output logic       free
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  res_entry_t  mem_q [DEPTH];
  res_entry_t  mem_d [DEPTH];
  logic        full, do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    free    = !full;
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d    = do_push ? wr_q + (AW+1)'(1) : wr_q;
    rd_d    = do_pop ? rd_q + (AW+1)'(1) : rd_q;
    mem_d   = mem_q;
    if (do_push) mem_d[wr_q[AW-1:0]] = push_entry;
    head    = mem_q[rd_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fib_req_driver.sv
// Issues one fib core request per index of a range command, one outstanding at a time,
// and queues index/value results (or timeout aborts) for a valid/ready consumer.
module fib_req_driver
  import fib_pkg::*;
#(
  parameter int IDX_W       = DEF_IDX_W,
  parameter int F_W         = DEF_F_W,
  parameter int MAX_IDX     = 30,
  parameter int RES_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [IDX_W-1:0] cmd_first,
  input  logic [IDX_W-1:0] cmd_count,
  output logic             fib_start,
  output logic [IDX_W-1:0] fib_i,
  input  logic             fib_ready,
  input  logic             fib_done_tick,
  input  logic [F_W-1:0]   fib_f,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [IDX_W-1:0] res_idx,
  output logic [F_W-1:0]   res_f,
  output logic             res_last,
  output logic             res_err,
  output logic             busy,
  output logic             timeout_sticky
);

  localparam int             TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W:0] MAX_EXT = (IDX_W+1)'(MAX_IDX);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cur_q, cur_d, last_q, last_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             sticky_q, sticky_d;
  logic             push, fifo_empty, fifo_free, issue_ok;
  res_entry_t       push_entry, head;
  logic [IDX_W:0]   first_ext, end_ext;

  // Range end is formed one bit wider so first+count cannot wrap before the clamp.
  assign first_ext = {1'b0, cmd_first};
  assign end_ext   = first_ext + {1'b0, cmd_count};
  // A request only goes out when its result is guaranteed a FIFO slot.
  assign issue_ok  = fib_ready && fifo_free;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      last_q   <= '0;
      timer_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      last_q   <= last_d;
      timer_q  <= timer_d;
      sticky_q <= sticky_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    last_d     = last_q;
    timer_d    = timer_q;
    sticky_d   = sticky_q;
    push       = 1'b0;
    push_entry = '0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (first_ext > MAX_EXT) begin
            push       = 1'b1;
            push_entry = '{idx: cmd_first, f: '0, last: 1'b1, err: 1'b1};
          end else begin
            cur_d   = cmd_first;
            last_d  = (end_ext > MAX_EXT) ? MAX_EXT[IDX_W-1:0] : end_ext[IDX_W-1:0];
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (issue_ok) begin
          timer_d = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A tick in the timeout cycle still counts as a normal result.
        if (fib_done_tick) begin
          push       = 1'b1;
          push_entry = '{idx: cur_q, f: fib_f, last: (cur_q == last_q), err: 1'b0};
          if (cur_q == last_q) begin
            state_d = IDLE;
          end else begin
            cur_d   = cur_q + IDX_W'(1);
            state_d = ISSUE;
          end
        end else if (timer_q == TO_LAST) begin
          push       = 1'b1;
          push_entry = '{idx: cur_q, f: '0, last: 1'b1, err: 1'b1};
          sticky_d   = 1'b1;
          state_d    = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready      = (state_q == IDLE);
    busy           = (state_q != IDLE);
    fib_start      = (state_q == ISSUE) && issue_ok && !reset;
    fib_i          = cur_q;
    timeout_sticky = sticky_q;
    res_valid      = !fifo_empty;
    res_idx        = fifo_empty ? '0 : head.idx;
    res_f          = fifo_empty ? '0 : head.f;
    res_last       = !fifo_empty && head.last;
    res_err        = !fifo_empty && head.err;
  end

  fib_res_fifo #(
    .DEPTH(RES_DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_entry(push_entry),
    .pop       (res_ready && !fifo_empty),
    .head      (head),
    .empty     (fifo_empty),
    .free      (fifo_free)
  );

endmodule

// File: tb/tb_fib_req_driver.sv
// Directed bench for fib_req_driver with a behavioural fib core and a result scoreboard.
module tb_fib_req_driver;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [4:0]  cmd_first, cmd_count;
  logic        fib_start;
  logic [4:0]  fib_i;
  logic        fib_ready, fib_done_tick;
  logic [19:0] fib_f;
  logic        res_valid, res_ready, res_last, res_err;
  logic [4:0]  res_idx;
  logic [19:0] res_f;
  logic        busy, timeout_sticky;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [26:0] exp_q[$];

  // Core model bookkeeping
  int         start_cnt      = 0;
  int         dbl_cnt        = 0;
  int         gap_cnt        = 0;
  int         tick_cyc       = -100;
  int         last_start_cyc = 0;
  int         core_cnt       = 0;
  logic [4:0] core_i         = '0;
  logic       prev_s         = 1'b0;
  logic       hang_en        = 1'b0;
  logic [4:0] hang_idx       = '0;

  fib_req_driver dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_first     (cmd_first),
    .cmd_count     (cmd_count),
    .fib_start     (fib_start),
    .fib_i         (fib_i),
    .fib_ready     (fib_ready),
    .fib_done_tick (fib_done_tick),
    .fib_f         (fib_f),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_idx       (res_idx),
    .res_f         (res_f),
    .res_last      (res_last),
    .res_err       (res_err),
    .busy          (busy),
    .timeout_sticky(timeout_sticky)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] fib_fn(input logic [4:0] n);
    logic [19:0] a, b, t;
    a = '0;
    b = 20'd1;
    for (int k = 0; k < int'(n); k++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Behavioural fib core: busy for LAT cycles per request, optionally never answers hang_idx.
  initial begin
    logic       s;
    logic [4:0] si;
    fib_ready     = 1'b1;
    fib_done_tick = 1'b0;
    fib_f         = '0;
    forever begin
      @(negedge clk);
      s  = fib_start;
      si = fib_i;
      if (s) begin
        start_cnt++;
        last_start_cyc = cyc;
        if (prev_s) dbl_cnt++;
        if (tick_cyc == cyc - 1) gap_cnt++;
      end
      prev_s = s;
      if (fib_done_tick) tick_cyc = cyc;
      @(posedge clk);
      #1;
      fib_done_tick = 1'b0;
      if (core_cnt != 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          fib_ready = 1'b1;
          if (!(hang_en && core_i == hang_idx)) begin
            fib_done_tick = 1'b1;
            fib_f         = fib_fn(core_i);
          end
        end
      end
      if (s) begin
        core_i    = si;
        core_cnt  = LAT;
        fib_ready = 1'b0;
      end
    end
  end

  // Scoreboard: every accepted result must match the head of exp_q.
  initial begin
    logic [26:0] e;
    forever begin
      @(negedge clk);
      if (!reset && res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("result", {res_idx, res_f, res_last, res_err}, e);
        end
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input logic [4:0] idx, input logic [19:0] f,
                          input logic last, input logic err);
    exp_q.push_back({idx, f, last, err});
  endtask

  task automatic send_cmd(input logic [4:0] first, input logic [4:0] count);
    check("cmd_ready", cmd_ready, 1);
    cmd_first = first;
    cmd_count = count;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    int n = 0;
    while (busy && n < max_cyc) begin
      step();
      n++;
    end
    check(tag, busy, 0);
  endtask

  task automatic wait_drain(input int max_cyc, input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || res_valid) && n < max_cyc) begin
      step();
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    int s0, g0;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_first = '0;
    cmd_count = '0;
    res_ready = 1'b0;
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_fib_start", fib_start, 0);
    check("rst_res_head", {res_idx, res_f, res_last, res_err}, 0);
    check("rst_sticky", timeout_sticky, 0);

    // Range 0..8 with a free-flowing consumer
    res_ready = 1'b1;
    push_exp(0, 0, 0, 0);   push_exp(1, 1, 0, 0);   push_exp(2, 1, 0, 0);
    push_exp(3, 2, 0, 0);   push_exp(4, 3, 0, 0);   push_exp(5, 5, 0, 0);
    push_exp(6, 8, 0, 0);   push_exp(7, 13, 0, 0);  push_exp(8, 21, 1, 0);
    s0 = start_cnt;
    g0 = gap_cnt;
    send_cmd(0, 8);
    check("t1_first_start", fib_start, 1);
    check("t1_first_idx", fib_i, 0);
    wait_idle(200, "t1_idle");
    wait_drain(20, "t1_drain");
    check("t1_starts", start_cnt - s0, 9);
    check("t1_tick_to_start", gap_cnt - g0, 8);

    // Range 10..13 into a stalled consumer: exactly fills the FIFO
    res_ready = 1'b0;
    s0 = start_cnt;
    send_cmd(10, 3);
    wait_idle(100, "t2_idle");
    check("t2_starts", start_cnt - s0, 4);
    check("t2_no_start", fib_start, 0);
    check("t2_res_valid", res_valid, 1);
    check("t2_head", {res_idx, res_f, res_last, res_err}, {5'd10, 20'd55, 1'b0, 1'b0});
    repeat (3) step();
    check("t2_head_hold", {res_idx, res_f, res_last, res_err}, {5'd10, 20'd55, 1'b0, 1'b0});
    push_exp(10, 55, 0, 0); push_exp(11, 89, 0, 0);
    push_exp(12, 144, 0, 0); push_exp(13, 233, 1, 0);
    res_ready = 1'b1;
    wait_drain(20, "t2_drain");
    check("t2_starts_after", start_cnt - s0, 4);

    // Range 0..5 into a stalled consumer: the fifth request must wait for space
    res_ready = 1'b0;
    s0 = start_cnt;
    send_cmd(0, 5);
    repeat (30) step();
    check("t2b_starts_stalled", start_cnt - s0, 4);
    check("t2b_busy", busy, 1);
    check("t2b_no_start", fib_start, 0);
    push_exp(0, 0, 0, 0); push_exp(1, 1, 0, 0); push_exp(2, 1, 0, 0);
    push_exp(3, 2, 0, 0); push_exp(4, 3, 0, 0); push_exp(5, 5, 1, 0);
    res_ready = 1'b1;
    wait_idle(100, "t2b_idle");
    wait_drain(20, "t2b_drain");
    check("t2b_starts", start_cnt - s0, 6);

    // Truncation at MAX_IDX
    push_exp(28, 317811, 0, 0); push_exp(29, 514229, 0, 0); push_exp(30, 832040, 1, 0);
    s0 = start_cnt;
    send_cmd(28, 7);
    wait_idle(100, "t3_idle");
    wait_drain(20, "t3_drain");
    check("t3_starts", start_cnt - s0, 3);

    // Core never answers index 3
    hang_en  = 1'b1;
    hang_idx = 5'd3;
    push_exp(2, 1, 0, 0);
    push_exp(3, 0, 1, 1);
    s0 = start_cnt;
    send_cmd(2, 4);
    wait_idle(1200, "t4_idle");
    check("t4_timeout_cycles", cyc - last_start_cyc, 1024);
    check("t4_sticky", timeout_sticky, 1);
    check("t4_cmd_ready", cmd_ready, 1);
    check("t4_err_head", {res_valid, res_idx, res_last, res_err}, {1'b1, 5'd3, 1'b1, 1'b1});
    wait_drain(20, "t4_drain");
    check("t4_starts", start_cnt - s0, 2);
    hang_en = 1'b0;

    // Reset while waiting on the core; its late tick must be dropped
    s0 = start_cnt;
    send_cmd(5, 3);
    check("t5_start", fib_start, 1);
    step();
    check("t5_in_wait", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_cmd_ready", cmd_ready, 1);
    check("t5_res_valid", res_valid, 0);
    check("t5_sticky_cleared", timeout_sticky, 0);
    repeat (8) step();
    check("t5_late_tick_dropped", res_valid, 0);
    check("t5_starts", start_cnt - s0, 1);

    // Reset in the issue cycle suppresses the start pulse
    s0 = start_cnt;
    send_cmd(5, 0);
    reset = 1'b1;
    #1;
    check("t5_start_in_reset", fib_start, 0);
    step();
    reset = 1'b0;
    check("t5_no_start_counted", start_cnt - s0, 0);

    push_exp(5, 5, 1, 0);
    send_cmd(5, 0);
    wait_idle(50, "t5_new_idle");
    wait_drain(20, "t5_new_drain");

    // Out-of-range first index
    push_exp(31, 0, 1, 1);
    s0 = start_cnt;
    send_cmd(31, 0);
    check("t6_busy", busy, 0);
    check("t6_res_valid", res_valid, 1);
    wait_drain(20, "t6_drain");
    repeat (3) step();
    check("t6_starts", start_cnt - s0, 0);
    check("t6_sticky", timeout_sticky, 0);

    check("single_cycle_start", dbl_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
